// File: rtl/vga_pattern_scheduler.sv
// Pixel-domain pattern sequencer: tracks active-pixel position from the timing qualifiers,
// switches between four test patterns only at frame boundaries and drives registered RGB.
module vga_pattern_scheduler #(
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480,
  parameter int BAR_W              = 80,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dValid_h,
  input  logic       dValid_v,
  input  logic [3:0] lfsr_r,
  input  logic [3:0] lfsr_g,
  input  logic [3:0] lfsr_b,
  input  logic       auto_en,
  input  logic       step,
  output logic       seed_load,
  output logic [1:0] pattern,
  output logic       frame_tick,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);
  localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int FW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [9:0]    X_MAX   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    Y_MAX   = 9'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_MAX = BW'(BAR_W - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          dvh_q, dvv_q;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [BW-1:0] barpx_q, barpx_d;
  logic [2:0]    bar_q, bar_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic [1:0]    pat_q, pat_d;
  logic          tick_q, tick_d;
  logic          seed_q, seed_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          active_s, line_end_s, frame_end_s, advance_s;

  assign active_s    = dValid_h & dValid_v;
  assign line_end_s  = dvh_q & ~dValid_h & dValid_v;
  assign frame_end_s = dvv_q & ~dValid_v;

  // Next-state: FSM, position counters, pattern sequencing and colour generation
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    barpx_d   = barpx_q;
    bar_d     = bar_q;
    fcnt_d    = fcnt_q;
    pat_d     = pat_q;
    tick_d    = 1'b0;
    seed_d    = 1'b0;
    advance_s = 1'b0;
    r_d       = 4'h0;
    g_d       = 4'h0;
    b_d       = 4'h0;
    case (state_q)
      ST_SYNC: begin
        x_d     = 10'd0;
        y_d     = 9'd0;
        barpx_d = '0;
        bar_d   = 3'd0;
        fcnt_d  = '0;
        // Wait for vertical blank so a partial frame is never drawn
        if (!dValid_v) begin
          state_d = ST_SHOW;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SHOW: begin
        if (frame_end_s) begin
          x_d     = 10'd0;
          y_d     = 9'd0;
          barpx_d = '0;
          bar_d   = 3'd0;
        end else if (line_end_s) begin
          x_d     = 10'd0;
          barpx_d = '0;
          bar_d   = 3'd0;
          y_d     = (y_q == Y_MAX) ? y_q : y_q + 9'd1;
        end else if (active_s) begin
          x_d = (x_q == X_MAX) ? x_q : x_q + 10'd1;
          if (barpx_q == BAR_MAX) begin
            barpx_d = '0;
            bar_d   = (bar_q == 3'd7) ? bar_q : bar_q + 3'd1;
          end else begin
            barpx_d = barpx_q + BW'(1);
            bar_d   = bar_q;
          end
        end else begin
          x_d = x_q;
        end

        if (frame_end_s) begin
          tick_d    = 1'b1;
          advance_s = (auto_en && (fcnt_q == FRM_MAX)) || pend_q || step;
          if (advance_s) begin
            pat_d  = pat_q + 2'd1;
            fcnt_d = '0;
            seed_d = (pat_q == 2'd3);
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end else begin
          tick_d = 1'b0;
        end

        if (active_s) begin
          case (pat_q)
            2'd0: begin
              r_d = lfsr_r;
              g_d = lfsr_g;
              b_d = lfsr_b;
            end
            2'd1: begin
              r_d = bar_q[1] ? 4'h0 : 4'hF;
              g_d = bar_q[2] ? 4'h0 : 4'hF;
              b_d = bar_q[0] ? 4'h0 : 4'hF;
            end
            2'd2: begin
              r_d = (x_q[5] ^ y_q[5]) ? 4'hF : 4'h0;
              g_d = r_d;
              b_d = r_d;
            end
            2'd3: begin
              r_d = x_q[9:6];
              g_d = y_q[8:5];
              b_d = 4'hF - x_q[9:6];
            end
            default: begin
              r_d = 4'h0;
              g_d = 4'h0;
              b_d = 4'h0;
            end
          endcase
        end else begin
          r_d = 4'h0;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (!auto_en) begin
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_d;
    end
    // A step is remembered until the boundary that consumes it
    if (advance_s) begin
      pend_d = 1'b0;
    end else if (step) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SYNC;
      dvh_q   <= 1'b0;
      dvv_q   <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
      barpx_q <= '0;
      bar_q   <= 3'd0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      pat_q   <= 2'd0;
      tick_q  <= 1'b0;
      seed_q  <= 1'b1;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
    end else begin
      state_q <= state_d;
      dvh_q   <= dValid_h;
      dvv_q   <= dValid_v;
      x_q     <= x_d;
      y_q     <= y_d;
      barpx_q <= barpx_d;
      bar_q   <= bar_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
      tick_q  <= tick_d;
      seed_q  <= seed_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign seed_load  = seed_q;
  assign pattern    = pat_q;
  assign frame_tick = tick_q;
  assign VGA_R      = r_q;
  assign VGA_G      = g_q;
  assign VGA_B      = b_q;
endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Bench for vga_pattern_scheduler: a frame table drives a scaled timing generator; every cycle's
// outputs go through a scoreboard fed by a reference model, plus fixed pixel and frame-end expectations.
module tb_vga_pattern_scheduler;
  localparam int FPP = 2;
  localparam int HB  = 4;
  localparam int VB  = 6;
  localparam int NF  = 19;
  localparam int NS  = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       dValid_h, dValid_v;
  logic [3:0] lfsr_r, lfsr_g, lfsr_b;
  logic       auto_en, step;
  logic       seed_load, frame_tick;
  logic [1:0] pattern;
  logic [3:0] VGA_R, VGA_G, VGA_B;

  always #5 clk = ~clk;

  vga_pattern_scheduler #(
    .H_ACTIVE(640), .V_ACTIVE(480), .BAR_W(80), .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .clk(clk), .reset(reset), .dValid_h(dValid_h), .dValid_v(dValid_v),
    .lfsr_r(lfsr_r), .lfsr_g(lfsr_g), .lfsr_b(lfsr_b),
    .auto_en(auto_en), .step(step), .seed_load(seed_load), .pattern(pattern),
    .frame_tick(frame_tick), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  pat;
    logic        tick;
    logic        seed;
  } obs_t;

  typedef struct {
    logic [1:0]  pat;
    int          x;
    int          y;
    logic [11:0] rgb;
  } spot_t;

  typedef struct {
    logic       auto_en;
    int         lines;
    int         ppl;
    int         nsteps;
    logic       step_end;
    int         rst_on;
    int         rst_off;
    logic [1:0] exp_pat;
    logic       exp_tick;
    logic       exp_seed;
  } frame_t;

  obs_t   sb[$];
  spot_t  spots[NS];
  int     spot_hits[NS];
  frame_t frames[NF];
  int     n_cmp = 0;
  int     n_bad = 0;

  logic       m_show, m_prev_v, m_pend;
  logic [1:0] m_pat;
  int         m_fcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    return {VGA_R, VGA_G, VGA_B, pattern, frame_tick, seed_load};
  endfunction

  function automatic logic [11:0] ref_colour(input logic [1:0] p, input int px, input int ln,
                                             input logic [11:0] noise);
    int x, y;
    logic [3:0] ramp;
    x = (px > 639) ? 639 : px;
    y = (ln > 479) ? 479 : ln;
    ramp = 4'(x / 64);
    case (p)
      2'd0: return noise;
      2'd1: begin
        case (x / 80)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      2'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
      default: return {ramp, 4'(y / 32), 4'hF - ramp};
    endcase
  endfunction

  task automatic model_cycle(input logic h, input logic v, input int px, input int ln,
                             output obs_t e, output int sidx);
    logic fe, adv;
    sidx = -1;
    if (reset) begin
      e = '{rgb: 12'h000, pat: 2'd0, tick: 1'b0, seed: 1'b1};
      m_show = 1'b0; m_prev_v = 1'b0; m_pat = 2'd0; m_fcnt = 0; m_pend = 1'b0;
    end else begin
      e.rgb = 12'h000;
      if (m_show && h && v) begin
        e.rgb = ref_colour(m_pat, px, ln, {lfsr_r, lfsr_g, lfsr_b});
        for (int i = 0; i < NS; i++)
          if (spots[i].pat == m_pat && spots[i].x == px && spots[i].y == ln) sidx = i;
      end
      fe  = m_show && m_prev_v && !v;
      adv = fe && ((auto_en && m_fcnt == FPP - 1) || m_pend || step);
      e.seed = 1'b0;
      if (adv) begin
        m_pat  = m_pat + 2'd1;
        m_fcnt = 0;
        e.seed = (m_pat == 2'd0);
      end else if (fe && auto_en) begin
        m_fcnt = m_fcnt + 1;
      end
      if (!auto_en) m_fcnt = 0;
      if (adv) m_pend = 1'b0;
      else if (step) m_pend = 1'b1;
      if (!m_show && !v) m_show = 1'b1;
      m_prev_v = v;
      e.tick = fe;
      e.pat  = m_pat;
    end
  endtask

  task automatic drive_cycle(input logic h, input logic v, input int px, input int ln);
    obs_t e, want;
    int   sidx;
    dValid_h = h;
    dValid_v = v;
    lfsr_r = 4'($urandom);
    lfsr_g = 4'($urandom);
    lfsr_b = 4'($urandom);
    model_cycle(h, v, px, ln, e, sidx);
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check($sformatf("cycle x=%0d y=%0d", px, ln), 32'(dut_obs()), 32'(want));
    if (sidx >= 0) begin
      spot_hits[sidx]++;
      check($sformatf("spot%0d", sidx), 32'({VGA_R, VGA_G, VGA_B}), 32'(spots[sidx].rgb));
    end
  endtask

  task automatic run_frame(input int idx);
    frame_t f;
    int c, sline;
    f = frames[idx];
    c = 0;
    auto_en = f.auto_en;
    sline = (f.lines > 1) ? 1 : 0;
    for (int ln = 0; ln < f.lines; ln++) begin
      for (int p = 0; p < f.ppl + HB; p++) begin
        if (c == f.rst_on)  reset = 1'b1;
        if (c == f.rst_off) reset = 1'b0;
        step = (ln == sline) && (p % 2 == 1) && (p / 2 < f.nsteps);
        drive_cycle(p < f.ppl, 1'b1, p, ln);
        c++;
      end
    end
    for (int k = 0; k < VB; k++) begin
      step = (k == 0) && f.step_end;
      drive_cycle(1'b0, 1'b0, 0, 0);
      if (k == 0)
        check($sformatf("frame%0d_end pat/tick/seed", idx),
              {28'd0, pattern, frame_tick, seed_load},
              {28'd0, f.exp_pat, f.exp_tick, f.exp_seed});
    end
    step = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    spots[0]  = '{2'd1,   0,  0, 12'hFFF};
    spots[1]  = '{2'd1,  79,  0, 12'hFFF};
    spots[2]  = '{2'd1,  80,  0, 12'hFF0};
    spots[3]  = '{2'd1, 159,  0, 12'hFF0};
    spots[4]  = '{2'd1, 560,  0, 12'h000};
    spots[5]  = '{2'd1, 639,  0, 12'h000};
    spots[6]  = '{2'd2,  31,  0, 12'h000};
    spots[7]  = '{2'd2,  32,  0, 12'hFFF};
    spots[8]  = '{2'd2,   0, 32, 12'hFFF};
    spots[9]  = '{2'd3,   0,  0, 12'h00F};
    spots[10] = '{2'd3, 639,  0, 12'h906};
    spots[11] = '{2'd3, 699,  0, 12'h906};
    for (int i = 0; i < NS; i++) spot_hits[i] = 0;

    //              auto  ln  ppl  st  end  rst_on rst_off pat  tick  seed
    frames[0]  = '{1'b0,  4,  64, 0, 1'b0, -1,  88, 2'd0, 1'b0, 1'b0};
    frames[1]  = '{1'b0,  4,  64, 0, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b0};
    frames[2]  = '{1'b0,  4,  64, 0, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b0};
    frames[3]  = '{1'b0,  4,  64, 1, 1'b0, -1,  -1, 2'd1, 1'b1, 1'b0};
    frames[4]  = '{1'b0,  2, 640, 3, 1'b0, -1,  -1, 2'd2, 1'b1, 1'b0};
    frames[5]  = '{1'b0, 33,  40, 0, 1'b1, -1,  -1, 2'd3, 1'b1, 1'b0};
    frames[6]  = '{1'b0,  1, 700, 0, 1'b0, -1,  -1, 2'd3, 1'b1, 1'b0};
    frames[7]  = '{1'b0,  2,  16, 1, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b1};
    frames[8]  = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b0};
    frames[9]  = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd1, 1'b1, 1'b0};
    frames[10] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd1, 1'b1, 1'b0};
    frames[11] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd2, 1'b1, 1'b0};
    frames[12] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd2, 1'b1, 1'b0};
    frames[13] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd3, 1'b1, 1'b0};
    frames[14] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd3, 1'b1, 1'b0};
    frames[15] = '{1'b1,  2,  16, 0, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b1};
    frames[16] = '{1'b1,  2,  16, 1, 1'b0, -1,  -1, 2'd1, 1'b1, 1'b0};
    frames[17] = '{1'b1,  4,  32, 0, 1'b0, 40,  50, 2'd0, 1'b0, 1'b0};
    frames[18] = '{1'b0,  2,  16, 0, 1'b0, -1,  -1, 2'd0, 1'b1, 1'b0};

    m_show = 1'b0; m_prev_v = 1'b0; m_pat = 2'd0; m_fcnt = 0; m_pend = 1'b0;
    reset = 1'b1; auto_en = 1'b0; step = 1'b0;
    dValid_h = 1'b0; dValid_v = 1'b0;
    lfsr_r = 4'h0; lfsr_g = 4'h0; lfsr_b = 4'h0;

    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 0, 0);
    check("reset_state", 32'(dut_obs()), 32'({12'h000, 2'd0, 1'b0, 1'b1}));

    for (int i = 0; i < NF; i++) run_frame(i);

    for (int i = 0; i < NS; i++)
      check($sformatf("spot%0d_reached", i), 32'(spot_hits[i] > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_pattern_scheduler.md
Name: vga_pattern_scheduler

Overview:
Pixel-domain controller that sequences the VGA colour datapath between four test patterns: LFSR noise, colour bars, checkerboard and gradient. It tracks active-pixel position from the timing generator's dValid_h/dValid_v qualifiers. It switches pattern only at frame boundaries, either automatically every N frames or on a manual step request, and issues LFSR reseed pulses. It sits between clockGen/lfsr instances and the VGA_R/G/B pins, replacing the fixed noise-and-mask assignment.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BAR_W, 80, colour-bar width in pixels (H_ACTIVE/8)
FRAMES_PER_PATTERN, 120, frames shown per pattern in auto mode (>=1)

Ports:
clk  input  1  pixel clock (25 MHz)
reset  input  1  synchronous, active-high reset
dValid_h  input  1  horizontal active-video qualifier
dValid_v  input  1  vertical active-video qualifier
lfsr_r  input  4  red noise value
lfsr_g  input  4  green noise value
lfsr_b  input  4  blue noise value
auto_en  input  1  1 = advance pattern every FRAMES_PER_PATTERN frames
step  input  1  single-cycle pulse: advance at next frame boundary
seed_load  output  1  reseed pulse to lfsr instances
pattern  output  2  current pattern: 0 NOISE, 1 BARS, 2 CHECKER, 3 GRADIENT
frame_tick  output  1  one-cycle pulse at each frame boundary
VGA_R  output  4  red
VGA_G  output  4  green
VGA_B  output  4  blue

Behaviour:
- One clock only; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: VGA_R/G/B=0, pattern=0, frame_tick=0, seed_load=1 (held while reset is high and for the first cycle after), x_cnt=0, y_cnt=0, frame counter=0, step_pending=0, state=SYNC.
- active = dValid_h & dValid_v.
- Edge detect: dValid_h and dValid_v are registered. "line end" = dValid_h falling while dValid_v=1. "frame end" = dValid_v falling.
- x_cnt[9:0]:
  - increments on each active cycle, saturating at H_ACTIVE-1;
  - cleared on line end;
  - a parallel bar counter wraps at BAR_W-1 and increments bar[2:0], which saturates at 7.
- y_cnt[8:0]: increments on line end, saturating at V_ACTIVE-1; cleared on frame end.
- FSM:
  - SYNC: outputs forced 0, counters held at 0. Moves to SHOW on the first cycle with dValid_v=0, so partial frames after reset are never drawn.
  - SHOW: normal drawing.
  - On frame end in SHOW:
    - frame_tick=1 for one cycle;
    - frame counter increments;
    - advance if (auto_en and counter==FRAMES_PER_PATTERN-1) or step_pending;
    - on advance: pattern<=pattern+1 (wraps 3->0), counter<=0, step_pending<=0.
    - If the new pattern is NOISE, seed_load=1 in the same cycle as frame_tick.
- step: sets step_pending (sticky). Multiple steps within one frame advance only once. step coincident with frame end advances at that boundary.
- auto_en=0: frame counter holds at 0; only step advances.
- Colour, registered with 1-cycle latency. Outputs at cycle n+1 are computed from cycle-n inputs and counters; 0 when active=0 at cycle n.
  - NOISE: {lfsr_r, lfsr_g, lfsr_b}.
  - BARS, bar 0..7: R=F for bars {0,1,4,5}, G=F for {0,1,2,3}, B=F for {0,2,4,6}, else 0. This gives white, yellow, cyan, green, magenta, red, blue, black.
  - CHECKER: all channels F when x_cnt[5]^y_cnt[5]=1, else 0.
  - GRADIENT: R=x_cnt[9:6], G=y_cnt[8:5], B=4'hF-x_cnt[9:6].
- pattern changes only at frame end, never mid-frame.
- Reset asserted mid-frame: everything returns to reset values; drawing resumes only after SYNC sees vertical blank.

Test Plan:
- Reset, then 2 full 640x480 frames with auto_en=0, pattern 0 -> outputs equal lfsr inputs delayed 1 cycle inside active video and 0 elsewhere; seed_load high during reset plus 1 cycle, then low.
- One step pulse mid-frame 0 -> pattern=1 exactly at the frame-0 end cycle, frame_tick=1 that cycle. Frame 1, line 0: pixels 0-79 = FFF, 80-159 = FF0, 560-639 = 000.
- Three step pulses in one frame -> pattern advances by exactly 1. Pattern 2, line 0: pixel 31 = 000, pixel 32 = FFF. Line 32, pixel 0 = FFF.
- FRAMES_PER_PATTERN=2, auto_en=1, 8 frames -> pattern sequence 0,0,1,1,2,2,3,3. seed_load pulses together with frame_tick at the 3->0 wrap.
- Reset released mid-active-line of frame -> VGA outputs stay 0 until the next vertical blank. The first drawn pixel is x=0, y=0 of the following frame.
- Gradient (pattern 3), line 0: pixel 639 = R=9, G=0, B=6. A line with 700 dValid_h cycles keeps x_cnt saturated at 639 with no wrap.
